// File: rtl/seven_segment_scan_ctrl.sv
// seven_segment_scan_ctrl: N-digit multiplexed 7-segment scanner with frame-synchronous
// input shadowing, per-digit blink, leading-zero blanking and PWM brightness.
module seven_segment_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int BRIGHT_W     = 3,
   parameter int BLINK_FRAMES = 125,
   parameter bit HEX_EN       = 0
) (
   input  logic                    CLOCK,
   input  logic                    RESET,
   input  logic                    ENABLE,
   input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
   input  logic [NUM_DIGITS-1:0]   DP_IN,
   input  logic [NUM_DIGITS-1:0]   BLINK_MASK,
   input  logic                    LZB_EN,
   input  logic [BRIGHT_W-1:0]     BRIGHTNESS,
   output logic [6:0]              SEG_OUT,
   output logic                    DP_OUT,
   output logic [NUM_DIGITS-1:0]   ANODES,
   output logic                    FRAME_TICK
);
   localparam int PW   = $clog2(SCAN_DIV);
   localparam int SW   = $clog2(NUM_DIGITS);
   localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int UNIT = SCAN_DIV >> BRIGHT_W;

   logic [PW-1:0]           presc;
   logic [SW-1:0]           slot;
   logic [FW-1:0]           frame_cnt;
   logic                    blink;
   logic [4*NUM_DIGITS-1:0] digits_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blink_sh;
   logic                    lzb_sh;
   logic [BRIGHT_W-1:0]     bright_sh;
   logic                    slot_end;
   logic                    frame_start;
   logic                    on;
   logic                    blank;
   logic                    run;
   logic                    lit;
   logic [3:0]              code;
   logic [6:0]              seg;
   logic [NUM_DIGITS-1:0]   zero_run;

   always_comb begin
      slot_end    = ENABLE && presc == PW'(SCAN_DIV - 1);
      frame_start = slot_end && slot == SW'(NUM_DIGITS - 1);
      on          = int'(presc) < (int'(bright_sh) + 1) * UNIT;
      code        = '0;
      run         = 1'b1;
      zero_run    = '0;
      // zero_run[i]: digit i and every digit left of it hold code 0
      for (int i = 0; i < NUM_DIGITS; i++) begin
         run = run && digits_sh[4*(NUM_DIGITS-1-i) +: 4] == 4'd0;
         zero_run[i] = run;
         if (slot == SW'(i)) code = digits_sh[4*(NUM_DIGITS-1-i) +: 4];
      end
      blank = (blink && blink_sh[slot]) ||
              (lzb_sh && slot != SW'(NUM_DIGITS - 1) && zero_run[slot]);
      lit   = ENABLE && on && !blank;
      case (code)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = HEX_EN ? 7'h08 : 7'h7F;
         4'hB:    seg = HEX_EN ? 7'h03 : 7'h7F;
         4'hC:    seg = HEX_EN ? 7'h46 : 7'h7F;
         4'hD:    seg = HEX_EN ? 7'h21 : 7'h7F;
         4'hE:    seg = HEX_EN ? 7'h06 : 7'h7F;
         default: seg = HEX_EN ? 7'h0E : 7'h7F;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         presc      <= '0;
         slot       <= '0;
         frame_cnt  <= '0;
         blink      <= 1'b0;
         digits_sh  <= '0;
         dp_sh      <= '0;
         blink_sh   <= '0;
         lzb_sh     <= 1'b0;
         bright_sh  <= '0;
         ANODES     <= '1;
         SEG_OUT    <= 7'h7F;
         DP_OUT     <= 1'b1;
         FRAME_TICK <= 1'b0;
      end else begin
         FRAME_TICK <= frame_start;
         ANODES     <= (ENABLE && on) ? ~(NUM_DIGITS'(1) << slot) : '1;
         SEG_OUT    <= lit ? seg : 7'h7F;
         DP_OUT     <= !(lit && dp_sh[slot]);
         if (slot_end) begin
            presc <= '0;
            slot  <= (slot == SW'(NUM_DIGITS - 1)) ? '0 : slot + SW'(1);
         end else if (ENABLE) begin
            presc <= presc + PW'(1);
         end
         if (frame_start) begin
            digits_sh <= DIGITS_IN;
            dp_sh     <= DP_IN;
            blink_sh  <= BLINK_MASK;
            lzb_sh    <= LZB_EN;
            bright_sh <= BRIGHTNESS;
            frame_cnt <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) blink <= ~blink;
         end
      end
   end
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// tb_seven_segment_scan_ctrl: directed frame-by-frame checks of the scanner, with a
// decimal-only and a hex-enabled instance driven from the same inputs.
module tb_seven_segment_scan_ctrl;
   localparam logic [27:0] Z    = {4{7'h40}};
   localparam logic [27:0] BL   = {4{7'h7F}};
   localparam logic [27:0] D1234 = {7'h79, 7'h24, 7'h30, 7'h19};

   logic        clk = 1'b0;
   logic        RESET, ENABLE, LZB_EN;
   logic [15:0] DIGITS_IN;
   logic [3:0]  DP_IN, BLINK_MASK, ANODES, hex_an;
   logic [2:0]  BRIGHTNESS;
   logic [6:0]  SEG_OUT, hex_seg;
   logic        DP_OUT, FRAME_TICK, hex_dp, hex_tick;
   int          vectors = 0;
   int          miscompares = 0;
   int          cur_f = 0;
   int          cur_c = 0;
   int          n;

   always #5 clk = ~clk;

   seven_segment_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BRIGHT_W(3), .BLINK_FRAMES(2), .HEX_EN(0)) dut (
      .CLOCK(clk), .RESET(RESET), .ENABLE(ENABLE), .DIGITS_IN(DIGITS_IN), .DP_IN(DP_IN),
      .BLINK_MASK(BLINK_MASK), .LZB_EN(LZB_EN), .BRIGHTNESS(BRIGHTNESS),
      .SEG_OUT(SEG_OUT), .DP_OUT(DP_OUT), .ANODES(ANODES), .FRAME_TICK(FRAME_TICK));

   seven_segment_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BRIGHT_W(3), .BLINK_FRAMES(2), .HEX_EN(1)) dut_hex (
      .CLOCK(clk), .RESET(RESET), .ENABLE(ENABLE), .DIGITS_IN(DIGITS_IN), .DP_IN(DP_IN),
      .BLINK_MASK(BLINK_MASK), .LZB_EN(LZB_EN), .BRIGHTNESS(BRIGHTNESS),
      .SEG_OUT(hex_seg), .DP_OUT(hex_dp), .ANODES(hex_an), .FRAME_TICK(hex_tick));

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s frame %0d cycle %0d: observed %0h expected %0h", tag, cur_f, cur_c, got, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_anodes", 32'(ANODES), 32'hF);
      chk("rst_seg", 32'(SEG_OUT), 32'h7F);
      chk("rst_dp", 32'(DP_OUT), 32'h1);
      chk("rst_tick", 32'(FRAME_TICK), 32'h0);
   endtask

   // Call at a frame-start cycle; checks the next 32 cycles and ends on the next frame start.
   task automatic check_frame(input logic [27:0] segs, input logic [27:0] hsegs, input logic [3:0] dpx,
                              input int lit, input int chg_c, input logic [15:0] chg_d);
      logic       on;
      logic [3:0] an;
      for (int s = 0; s < 4; s++) begin
         for (int p = 0; p < 8; p++) begin
            cur_c = s * 8 + p + 1;
            if (cur_c == chg_c) DIGITS_IN = chg_d;
            step(1);
            on = p < lit;
            an = on ? ~(4'b0001 << s) : 4'hF;
            chk("anodes", 32'(ANODES), 32'(an));
            chk("seg", 32'(SEG_OUT), on ? 32'(segs[27-7*s -: 7]) : 32'h7F);
            chk("dp", 32'(DP_OUT), on ? 32'(dpx[s]) : 32'h1);
            chk("tick", 32'(FRAME_TICK), 32'(cur_c == 32));
            chk("hex_anodes", 32'(hex_an), 32'(an));
            chk("hex_seg", 32'(hex_seg), on ? 32'(hsegs[27-7*s -: 7]) : 32'h7F);
            chk("hex_dp", 32'(hex_dp), on ? 32'(dpx[s]) : 32'h1);
            chk("hex_tick", 32'(hex_tick), 32'(cur_c == 32));
         end
      end
      cur_f++;
   endtask

   initial begin
      RESET = 1'b1; ENABLE = 1'b1; DIGITS_IN = 16'h1234; DP_IN = 4'h0;
      BLINK_MASK = 4'h0; LZB_EN = 1'b0; BRIGHTNESS = 3'd7;
      step(2);
      chk_reset();
      RESET = 1'b0;
      // F0: shadows still zero, so code 0 at minimum brightness
      check_frame(Z, Z, 4'hF, 1, 0, 16'h0);
      DIGITS_IN = 16'h0005; LZB_EN = 1'b1; DP_IN = 4'b1001;
      check_frame(D1234, D1234, 4'hF, 8, 0, 16'h0);
      DIGITS_IN = 16'h0000; DP_IN = 4'h0;
      check_frame({7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b0111, 8, 0, 16'h0);
      DIGITS_IN = 16'h1234; LZB_EN = 1'b0; BLINK_MASK = 4'b0011;
      check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 8, 0, 16'h0);
      // F4..F7: blink phase 0 for two frames, then 1 for two frames
      check_frame(D1234, D1234, 4'hF, 8, 0, 16'h0);
      check_frame(D1234, D1234, 4'hF, 8, 0, 16'h0);
      check_frame({7'h7F, 7'h7F, 7'h30, 7'h19}, {7'h7F, 7'h7F, 7'h30, 7'h19}, 4'hF, 8, 0, 16'h0);
      BLINK_MASK = 4'h0; BRIGHTNESS = 3'd1;
      check_frame({7'h7F, 7'h7F, 7'h30, 7'h19}, {7'h7F, 7'h7F, 7'h30, 7'h19}, 4'hF, 8, 0, 16'h0);
      // F8: digits change mid-frame, must not show until the next frame
      check_frame(D1234, D1234, 4'hF, 2, 12, 16'hABCF);
      DIGITS_IN = 16'h1234; BRIGHTNESS = 3'd7;
      check_frame(BL, {7'h08, 7'h03, 7'h46, 7'h0E}, 4'hF, 2, 0, 16'h0);
      // F10: pause five cycles in slot 1 and resume with the remaining count
      step(11);
      cur_c = 11;
      chk("pre_en_anodes", 32'(ANODES), 32'b1101);
      chk("pre_en_seg", 32'(SEG_OUT), 32'h24);
      ENABLE = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("dis_anodes", 32'(ANODES), 32'hF);
         chk("dis_seg", 32'(SEG_OUT), 32'h7F);
         chk("dis_dp", 32'(DP_OUT), 32'h1);
         chk("dis_tick", 32'(FRAME_TICK), 32'h0);
      end
      ENABLE = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("res_anodes", 32'(ANODES), 32'b1101);
         chk("res_seg", 32'(SEG_OUT), 32'h24);
      end
      step(1);
      chk("res_next_anodes", 32'(ANODES), 32'b1011);
      chk("res_next_seg", 32'(SEG_OUT), 32'h30);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!FRAME_TICK && n < 40);
      chk("resume_len", 32'(n), 32'd15);
      // F11: reset mid-frame with ENABLE held high
      cur_f++;
      step(10);
      RESET = 1'b1;
      step(1);
      chk_reset();
      RESET = 1'b0;
      cur_f = 0;
      check_frame(Z, Z, 4'hF, 1, 0, 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
